// File: rtl/stopwatch_time_counter_pkg.sv
// Stopwatch shared definitions: edit-mode state codes
// and BCD digit constants used by the FSM and the datapath.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        IDLE_S       = 3'd0,
        CHANGE_H_S   = 3'd1,
        CHANGE_TS_S  = 3'd2,
        CHANGE_SEC_S = 3'd3,
        CHANGE_T_S   = 3'd4
    } state_e;

    localparam int          DIGIT_W = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;

endpackage

// File: rtl/stopwatch_time_counter_if.sv
// Stopwatch time-counter bus: control in from the edit FSM,
// run flag / tick / BCD digits out to the FSM and display.
interface stopwatch_time_counter_if;
    import stopwatch_pkg::*;

    logic               start_i;
    logic               clear_i;
    logic [2:0]         state_value_i;
    logic               inc_this_i;
    logic               dev_run_o;
    logic               tick_o;
    logic [DIGIT_W-1:0] hundredths_o;
    logic [DIGIT_W-1:0] tenths_o;
    logic [DIGIT_W-1:0] seconds_o;
    logic [DIGIT_W-1:0] tens_o;

    modport master (
        output start_i, clear_i, state_value_i, inc_this_i,
        input  dev_run_o, tick_o,
        input  hundredths_o, tenths_o, seconds_o, tens_o
    );

    modport slave (
        input  start_i, clear_i, state_value_i, inc_this_i,
        output dev_run_o, tick_o,
        output hundredths_o, tenths_o, seconds_o, tens_o
    );

endinterface

// File: rtl/stopwatch_time_counter_bcd_digit_counter.sv
// Single BCD digit: synchronous clear, +1 mod 10 on inc,
// carry_o flags the 9 -> 0 rollover of this cycle.
module bcd_digit_counter
    import stopwatch_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic               clr,
    input  logic               inc,
    output logic [DIGIT_W-1:0] digit,
    output logic               carry_o
);

    logic [DIGIT_W-1:0] r_digit;

    assign digit   = r_digit;
    assign carry_o = inc & (r_digit == BCD_MAX);

    // Digit register; clear has priority, out-of-range wraps to 0
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_digit <= '0;
        end else if (clr) begin
            r_digit <= '0;
        end else if (inc) begin
            if (r_digit >= BCD_MAX)
                r_digit <= '0;
            else
                r_digit <= r_digit + DIGIT_W'(1);
        end
    end

endmodule

// File: rtl/stopwatch_time_counter.sv
// Stopwatch time-keeping datapath: 100 Hz prescaler, run flag,
// four cascaded BCD digits with no-carry edit increments.
module stopwatch_time_counter
    import stopwatch_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TICK_HZ     = 100
) (
    input  logic clk_i,
    input  logic rstn_i,
    stopwatch_time_counter_if.slave bus
);

    localparam int PULSE_MAX = CLK_FREQ_HZ / TICK_HZ - 1;
    localparam int PW = (PULSE_MAX < 2) ? 1 : $clog2(PULSE_MAX + 1);
    localparam logic [PW-1:0] PMAX = PW'(PULSE_MAX);

    logic          r_run;
    logic          r_tick;
    logic [PW-1:0] r_presc;

    logic w_tick;
    logic w_clr;
    logic w_edit_h;
    logic w_edit_t;
    logic w_edit_s;
    logic w_edit_ts;
    logic w_inc_h;
    logic w_inc_t;
    logic w_inc_s;
    logic w_inc_ts;
    logic w_carry_h;
    logic w_carry_t;
    logic w_carry_s;
    logic w_unused_wrap;

    assign w_tick = r_run & (r_presc == PMAX);
    assign w_clr  = bus.clear_i & ~r_run;

    // Edit-digit select; only honoured while stopped
    always_comb begin
        w_edit_h  = 1'b0;
        w_edit_t  = 1'b0;
        w_edit_s  = 1'b0;
        w_edit_ts = 1'b0;
        if (!r_run && bus.inc_this_i) begin
            case (bus.state_value_i)
                CHANGE_H_S:   w_edit_h  = 1'b1;
                CHANGE_T_S:   w_edit_t  = 1'b1;
                CHANGE_SEC_S: w_edit_s  = 1'b1;
                CHANGE_TS_S:  w_edit_ts = 1'b1;
                default:      ;
            endcase
        end
    end

    // Carries only propagate while running so edits never ripple
    assign w_inc_h  = w_tick | w_edit_h;
    assign w_inc_t  = (w_carry_h & r_run) | w_edit_t;
    assign w_inc_s  = (w_carry_t & r_run) | w_edit_s;
    assign w_inc_ts = (w_carry_s & r_run) | w_edit_ts;

    // Run flag and prescaler; prescaler holds while stopped
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_run   <= 1'b0;
            r_tick  <= 1'b0;
            r_presc <= '0;
        end else begin
            r_tick <= w_tick;
            if (bus.start_i)
                r_run <= ~r_run;
            if (w_clr)
                r_presc <= '0;
            else if (w_tick)
                r_presc <= '0;
            else if (r_run)
                r_presc <= r_presc + PW'(1);
        end
    end

    assign bus.dev_run_o = r_run;
    assign bus.tick_o    = r_tick;

    bcd_digit_counter u_hund (
        .clk     (clk_i),
        .rstn    (rstn_i),
        .clr     (w_clr),
        .inc     (w_inc_h),
        .digit   (bus.hundredths_o),
        .carry_o (w_carry_h)
    );

    bcd_digit_counter u_tenth (
        .clk     (clk_i),
        .rstn    (rstn_i),
        .clr     (w_clr),
        .inc     (w_inc_t),
        .digit   (bus.tenths_o),
        .carry_o (w_carry_t)
    );

    bcd_digit_counter u_sec (
        .clk     (clk_i),
        .rstn    (rstn_i),
        .clr     (w_clr),
        .inc     (w_inc_s),
        .digit   (bus.seconds_o),
        .carry_o (w_carry_s)
    );

    bcd_digit_counter u_tens (
        .clk     (clk_i),
        .rstn    (rstn_i),
        .clr     (w_clr),
        .inc     (w_inc_ts),
        .digit   (bus.tens_o),
        .carry_o (w_unused_wrap)
    );

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Stopwatch time-counter bench: vector table, directed
// corner sequences and random stimulus against a model.
module tb_stopwatch_time_counter;

    localparam int CLK_HZ = 1000;
    localparam int TCK_HZ = 100;
    localparam int PMAX   = CLK_HZ / TCK_HZ - 1;

    logic clk = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    stopwatch_time_counter_if bus ();

    stopwatch_time_counter #(
        .CLK_FREQ_HZ (CLK_HZ),
        .TICK_HZ     (TCK_HZ)
    ) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    int checks = 0;
    int failures = 0;

    // behavioural model
    bit m_run;
    bit m_tick;
    int m_pc;
    int m_d[4];

    typedef struct {
        bit         st;
        bit         cl;
        logic [2:0] sv;
        bit         inc;
        bit         e_run;
        logic [15:0] e_dig;
    } vec_t;

    vec_t vt[14];

    function automatic logic [15:0] dut_dig();
        return {bus.tens_o, bus.seconds_o, bus.tenths_o, bus.hundredths_o};
    endfunction

    function automatic logic [15:0] mdl_dig();
        return {4'(m_d[3]), 4'(m_d[2]), 4'(m_d[1]), 4'(m_d[0])};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0;
        m_tick = 0;
        m_pc = 0;
        for (int i = 0; i < 4; i++) m_d[i] = 0;
    endtask

    task automatic model_step(input bit st, input bit cl,
                              input logic [2:0] sv, input bit inc);
        bit tk;
        int v;
        tk = m_run && (m_pc == PMAX);
        if (!m_run && cl) begin
            m_pc = 0;
            for (int i = 0; i < 4; i++) m_d[i] = 0;
        end else if (m_run) begin
            if (tk) begin
                m_pc = 0;
                v = m_d[3] * 1000 + m_d[2] * 100 + m_d[1] * 10 + m_d[0];
                v = (v + 1) % 10000;
                m_d[0] = v % 10;
                m_d[1] = (v / 10) % 10;
                m_d[2] = (v / 100) % 10;
                m_d[3] = v / 1000;
            end else begin
                m_pc++;
            end
        end else if (inc) begin
            case (sv)
                3'd1: m_d[0] = (m_d[0] + 1) % 10;
                3'd4: m_d[1] = (m_d[1] + 1) % 10;
                3'd3: m_d[2] = (m_d[2] + 1) % 10;
                3'd2: m_d[3] = (m_d[3] + 1) % 10;
                default: ;
            endcase
        end
        if (st) m_run = !m_run;
        m_tick = tk;
    endtask

    // one clock: drive, advance model, compare after the edge
    task automatic step(input bit st, input bit cl,
                        input logic [2:0] sv, input bit inc);
        bus.start_i = st;
        bus.clear_i = cl;
        bus.state_value_i = sv;
        bus.inc_this_i = inc;
        model_step(st, cl, sv, inc);
        @(posedge clk);
        #1;
        check("model", {14'd0, bus.dev_run_o, bus.tick_o, dut_dig()},
              {14'd0, m_run, m_tick, mdl_dig()});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 3'd0, 0);
    endtask

    task automatic preload(input int ts, input int s, input int t,
                           input int h);
        step(0, 1, 3'd0, 0);
        for (int i = 0; i < ts; i++) step(0, 0, 3'd2, 1);
        for (int i = 0; i < s; i++) step(0, 0, 3'd3, 1);
        for (int i = 0; i < t; i++) step(0, 0, 3'd4, 1);
        for (int i = 0; i < h; i++) step(0, 0, 3'd1, 1);
    endtask

    initial begin
        int n;
        bit seen;

        vt[0]  = '{0, 0, 3'd1, 1, 0, 16'h0001};
        vt[1]  = '{0, 0, 3'd1, 1, 0, 16'h0002};
        vt[2]  = '{0, 0, 3'd4, 1, 0, 16'h0012};
        vt[3]  = '{0, 0, 3'd3, 1, 0, 16'h0112};
        vt[4]  = '{0, 0, 3'd2, 1, 0, 16'h1112};
        vt[5]  = '{0, 0, 3'd0, 1, 0, 16'h1112};
        vt[6]  = '{0, 0, 3'd5, 1, 0, 16'h1112};
        vt[7]  = '{0, 0, 3'd7, 1, 0, 16'h1112};
        vt[8]  = '{0, 0, 3'd1, 0, 0, 16'h1112};
        vt[9]  = '{0, 1, 3'd1, 1, 0, 16'h0000};
        vt[10] = '{1, 0, 3'd2, 1, 1, 16'h1000};
        vt[11] = '{0, 1, 3'd0, 0, 1, 16'h1000};
        vt[12] = '{1, 0, 3'd0, 0, 0, 16'h1000};
        vt[13] = '{0, 1, 3'd0, 0, 0, 16'h0000};

        bus.start_i = 0;
        bus.clear_i = 0;
        bus.state_value_i = 3'd0;
        bus.inc_this_i = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #3 rstn = 1'b1;
        @(posedge clk);
        #1;
        check("reset", {14'd0, bus.dev_run_o, bus.tick_o, dut_dig()}, 32'd0);

        // vector table: edits, no-carry, clear priority, start/clear
        foreach (vt[i]) begin
            step(vt[i].st, vt[i].cl, vt[i].sv, vt[i].inc);
            check($sformatf("vec%0d_run", i), {31'd0, bus.dev_run_o},
                  {31'd0, vt[i].e_run});
            check($sformatf("vec%0d_dig", i), {16'd0, dut_dig()},
                  {16'd0, vt[i].e_dig});
        end

        // start latency and first tick after PULSE_MAX+1 cycles
        step(1, 0, 3'd0, 0);
        check("start_run", {31'd0, bus.dev_run_o}, 32'd1);
        n = 0;
        seen = 0;
        while (!seen && n < 50) begin
            step(0, 0, 3'd0, 0);
            n++;
            seen = bus.tick_o;
        end
        check("first_tick_lat", n, PMAX + 1);
        check("first_tick_h", {28'd0, bus.hundredths_o}, 32'd1);
        step(1, 0, 3'd0, 0);

        // cascade 09.99 -> 10.00
        preload(0, 9, 9, 9);
        check("pre0999", {16'd0, dut_dig()}, 32'h0999);
        step(1, 0, 3'd0, 0);
        idle(PMAX + 1);
        check("casc1000", {16'd0, dut_dig()}, 32'h1000);
        step(1, 0, 3'd0, 0);

        // full wrap 99.99 -> 00.00, keeps running
        preload(9, 9, 9, 9);
        step(1, 0, 3'd0, 0);
        idle(PMAX + 1);
        check("wrap_dig", {16'd0, dut_dig()}, 32'h0000);
        check("wrap_run", {31'd0, bus.dev_run_o}, 32'd1);
        step(1, 0, 3'd0, 0);

        // edit on 9 wraps without carry
        preload(0, 0, 0, 9);
        step(0, 0, 3'd1, 1);
        check("edit_h0", {16'd0, dut_dig()}, 32'h0000);
        step(0, 0, 3'd1, 1);
        step(0, 0, 3'd1, 1);
        check("edit_h2", {16'd0, dut_dig()}, 32'h0002);

        // held prescaler across stop/restart; clear ignored running
        step(0, 1, 3'd0, 0);
        step(1, 0, 3'd0, 0);
        idle(3);
        step(0, 1, 3'd0, 0);
        check("clr_running", {31'd0, bus.dev_run_o}, 32'd1);
        step(1, 0, 3'd0, 0);
        idle(4);
        step(1, 0, 3'd0, 0);
        n = 1;
        seen = 0;
        while (!seen && n < 50) begin
            step(0, 0, 3'd0, 0);
            n++;
            seen = bus.tick_o;
        end
        check("restart_lat", n, 6);
        check("restart_h", {28'd0, bus.hundredths_o}, 32'd1);

        // start coincident with tick
        idle(PMAX);
        step(1, 0, 3'd0, 0);
        check("st_tick_t", {31'd0, bus.tick_o}, 32'd1);
        check("st_tick_h", {28'd0, bus.hundredths_o}, 32'd2);
        check("st_tick_run", {31'd0, bus.dev_run_o}, 32'd0);

        // random stimulus
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 39) == 0, $urandom_range(0, 14) == 0,
                 3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1);
        end

        // asynchronous reset mid-run
        if (!m_run) step(1, 0, 3'd0, 0);
        idle(PMAX + 3);
        #3 rstn = 1'b0;
        #1;
        check("async_rst", {14'd0, bus.dev_run_o, bus.tick_o, dut_dig()},
              32'd0);
        model_reset();
        @(posedge clk);
        #3 rstn = 1'b1;
        step(1, 0, 3'd0, 0);
        idle(PMAX + 1);
        check("post_rst_h", {28'd0, bus.hundredths_o}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
